iis_receiver: RTL and testbench

//  I2S (Philips) serial-to-parallel receiver, downstream of the I2S sender on the same board link.

---
 rtl/iis_pkg.sv | 18 +
 rtl/iis_rx_fifo.sv | 67 ++++++
 rtl/iis_receiver.sv | 149 ++++++++++++++
 tb/tb_iis_receiver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iis_pkg.sv
// -----------------------------------------------------------------------------
// iis_pkg: shared word width, channel tags and receiver FSM encoding. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none
package iis_pkg;

  localparam int IIS_DATA_W = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [0:0] {
    UNSYNC = 1'b0,
    RUN    = 1'b1
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/iis_rx_fifo.sv
// -----------------------------------------------------------------------------
// iis_rx_fifo: show-ahead receive FIFO with occupancy count and sticky overflow. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none
module iis_rx_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      usedw,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign empty   = (usedw == '0);
  assign full    = (usedw == (AW+1)'(DEPTH));
  assign do_pop  = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = wr_en & (~full | do_pop);
  assign drop    = wr_en & full & ~do_pop;
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      usedw    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   usedw <= usedw + (AW+1)'(1);
        2'b01:   usedw <= usedw - (AW+1)'(1);
        default: usedw <= usedw;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/iis_receiver.sv
// -----------------------------------------------------------------------------
// iis_receiver: Philips I2S receiver, oversampled in pclk, words queued in a FIFO. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none
module iis_receiver
  import iis_pkg::*;
#(
  parameter int DATA_W     = IIS_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 3
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              bclk,
  input  logic              lrck,
  input  logic              data,
  input  logic              rdreq,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] dataout,
  output logic              chan,
  output logic              rd_empty,
  output logic [AW:0]       rd_usedw,
  output logic              overflow,
  output logic              frame_err
);

  localparam int CW = $clog2(DATA_W + 1);

  logic bclk_s1, bclk_s2, bclk_s3;
  logic lrck_s1, lrck_s2;
  logic data_s1, data_s2;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_s3 <= 1'b0;
      lrck_s1 <= 1'b0;
      lrck_s2 <= 1'b0;
      data_s1 <= 1'b0;
      data_s2 <= 1'b0;
    end else begin
      bclk_s1 <= bclk;
      bclk_s2 <= bclk_s1;
      bclk_s3 <= bclk_s2;
      lrck_s1 <= lrck;
      lrck_s2 <= lrck_s1;
      data_s1 <= data;
      data_s2 <= data_s1;
    end
  end

  logic              bit_en;
  logic              word_end;
  logic              cnt_full;
  logic              ws_prev;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_upd;
  logic [CW-1:0]     bitcnt;
  logic [CW-1:0]     cnt_upd;

  assign bit_en   = bclk_s2 & ~bclk_s3;
  assign word_end = bit_en & (lrck_s2 != ws_prev);
  // Bits past DATA_W are ignored so long words keep their MSBs.
  assign cnt_full = (bitcnt == CW'(DATA_W));
  assign sr_upd   = cnt_full ? sr : {sr[DATA_W-2:0], data_s2};
  assign cnt_upd  = cnt_full ? bitcnt : bitcnt + CW'(1);

  rx_state_e state;
  rx_state_e state_nxt;
  logic      push_c;
  logic      ferr_c;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= UNSYNC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == UNSYNC && word_end) begin
      state_nxt = RUN;
    end
  end

  always_comb begin
    push_c = 1'b0;
    ferr_c = 1'b0;
    if (state == RUN && word_end) begin
      if (cnt_upd == CW'(DATA_W)) begin
        push_c = 1'b1;
      end else begin
        ferr_c = 1'b1;
      end
    end
  end

  logic              push_r;
  logic [DATA_W:0]   push_word;
  logic [DATA_W:0]   head;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ws_prev   <= CH_LEFT;
      sr        <= '0;
      bitcnt    <= '0;
      push_r    <= 1'b0;
      push_word <= '0;
      frame_err <= 1'b0;
    end else begin
      push_r    <= push_c;
      frame_err <= ferr_c;
      if (push_c) begin
        // The word-ending bit is sampled with the new WS, so the tag is the old one.
        push_word <= {ws_prev, sr_upd};
      end
      if (bit_en) begin
        ws_prev <= lrck_s2;
        sr      <= sr_upd;
        bitcnt  <= word_end ? '0 : cnt_upd;
      end
    end
  end

  iis_rx_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (pclk),
    .rst_n    (presetn),
    .wr_en    (push_r),
    .wr_data  (push_word),
    .rd_en    (rdreq),
    .ovf_clr  (ovf_clr),
    .rd_data  (head),
    .empty    (rd_empty),
    .usedw    (rd_usedw),
    .overflow (overflow)
  );

  assign dataout = head[DATA_W-1:0];
  assign chan    = head[DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_iis_receiver.sv
// -----------------------------------------------------------------------------
// tb_iis_receiver: directed I2S BFM bench for iis_receiver. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps
module tb_iis_receiver;

  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int AW         = 3;

  logic              pclk    = 1'b0;
  logic              presetn = 1'b0;
  logic              bclk    = 1'b0;
  logic              lrck    = 1'b0;
  logic              data    = 1'b0;
  logic              rdreq   = 1'b0;
  logic              ovf_clr = 1'b0;
  logic [DATA_W-1:0] dataout;
  logic              chan;
  logic              rd_empty;
  logic [AW:0]       rd_usedw;
  logic              overflow;
  logic              frame_err;

  int nvec = 0;
  int nerr = 0;
  int ferr_seen = 0;

  logic [15:0] vals [9] = '{16'h8001, 16'h4002, 16'h2004, 16'h1008, 16'h0810,
                            16'h0420, 16'h0240, 16'h0180, 16'hFFFF};

  iis_receiver #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .bclk      (bclk),
    .lrck      (lrck),
    .data      (data),
    .rdreq     (rdreq),
    .ovf_clr   (ovf_clr),
    .dataout   (dataout),
    .chan      (chan),
    .rd_empty  (rd_empty),
    .rd_usedw  (rd_usedw),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #125 pclk = ~pclk;

  always @(negedge pclk) begin
    if (frame_err === 1'b1) ferr_seen <= ferr_seen + 1;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // One bclk period = 8 pclk; called and returning on a pclk falling edge.
  task automatic send_bit(input logic ws, input logic sd, input logic pop_at_push);
    bclk = 1'b0;
    lrck = ws;
    data = sd;
    repeat (4) @(negedge pclk);
    bclk = 1'b1;
    repeat (3) @(negedge pclk);
    rdreq = pop_at_push;
    @(negedge pclk);
    rdreq = 1'b0;
  endtask

  // Philips timing: WS flips for the LSB, one bit ahead of the next word's MSB.
  task automatic send_word(input logic ws, input logic [31:0] val, input int nbits,
                           input logic next_ws, input logic pop_at_end);
    for (int k = nbits - 1; k >= 0; k--) begin
      send_bit((k == 0) ? next_ws : ws, val[k], (k == 0) && pop_at_end);
    end
  endtask

  task automatic pop_one();
    rdreq = 1'b1;
    @(negedge pclk);
    rdreq = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge pclk);
    bclk = 1'b0; lrck = 1'b0; data = 1'b0; rdreq = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic test_reset();
    @(negedge pclk);
    presetn = 1'b0;
    bclk = 1'b0;
    @(negedge pclk);
    nvec++; if (rd_empty !== 1'b1) begin nerr++; $display("FAIL reset_empty: got %b want 1", rd_empty); end
    nvec++; if (rd_usedw !== 4'd0) begin nerr++; $display("FAIL reset_usedw: got %0d want 0", rd_usedw); end
    nvec++; if ({chan, dataout} !== 17'h0) begin nerr++; $display("FAIL reset_head: got %h want 0", {chan, dataout}); end
    nvec++; if ({overflow, frame_err} !== 2'b00) begin nerr++; $display("FAIL reset_flags: got %b want 00", {overflow, frame_err}); end
    presetn = 1'b1;
  endtask

  task automatic test_basic_stream();
    int f0;
    apply_reset();
    f0 = ferr_seen;
    send_word(1'b0, 32'h98C3, 16, 1'b1, 1'b0);
    repeat (2) @(negedge pclk);
    nvec++; if (rd_usedw !== 4'd0) begin nerr++; $display("FAIL sync_drop: usedw got %0d want 0", rd_usedw); end
    send_word(1'b1, 32'hA380, 16, 1'b0, 1'b0);
    nvec++; if (rd_usedw !== 4'd1) begin nerr++; $display("FAIL basic_usedw1: got %0d want 1", rd_usedw); end
    nvec++; if ({rd_empty, chan, dataout} !== {1'b0, 1'b1, 16'hA380}) begin nerr++; $display("FAIL basic_head_r: got %h want 0_1_a380", {rd_empty, chan, dataout}); end
    send_word(1'b0, 32'hDF48, 16, 1'b1, 1'b0);
    nvec++; if (rd_usedw !== 4'd2) begin nerr++; $display("FAIL basic_usedw2: got %0d want 2", rd_usedw); end
    pop_one();
    nvec++; if (rd_usedw !== 4'd1) begin nerr++; $display("FAIL basic_usedw3: got %0d want 1", rd_usedw); end
    nvec++; if ({chan, dataout} !== {1'b0, 16'hDF48}) begin nerr++; $display("FAIL basic_head_l: got %h want 0df48", {chan, dataout}); end
    pop_one();
    nvec++; if (rd_usedw !== 4'd0) begin nerr++; $display("FAIL basic_usedw4: got %0d want 0", rd_usedw); end
    nvec++; if ({rd_empty, chan, dataout} !== {1'b1, 17'h0}) begin nerr++; $display("FAIL empty_head_zero: got %h want 1_0_0000", {rd_empty, chan, dataout}); end
    rdreq = 1'b1;
    repeat (2) @(negedge pclk);
    rdreq = 1'b0;
    @(negedge pclk);
    nvec++; if ({rd_empty, rd_usedw} !== {1'b1, 4'd0}) begin nerr++; $display("FAIL rdreq_empty: got empty=%b usedw=%0d want 1/0", rd_empty, rd_usedw); end
    nvec++; if (ferr_seen - f0 !== 0) begin nerr++; $display("FAIL basic_no_ferr: got %0d pulses want 0", ferr_seen - f0); end
  endtask

  task automatic test_overflow();
    apply_reset();
    send_word(1'b0, 32'h5555, 16, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      send_word(~i[0], {16'h0, vals[i]}, 16, i[0], 1'b0);
    end
    repeat (2) @(negedge pclk);
    nvec++; if (rd_usedw !== 4'd8) begin nerr++; $display("FAIL ovf_usedw: got %0d want 8", rd_usedw); end
    nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_set: got %b want 1", overflow); end
    ovf_clr = 1'b1;
    @(negedge pclk);
    ovf_clr = 1'b0;
    @(negedge pclk);
    nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    for (int i = 0; i < 8; i++) begin
      nvec++;
      if ({rd_empty, chan, dataout} !== {1'b0, ~i[0], vals[i]}) begin
        nerr++; $display("FAIL ovf_order[%0d]: got %h want %h", i, {rd_empty, chan, dataout}, {1'b0, ~i[0], vals[i]});
      end
      pop_one();
    end
    nvec++; if (rd_empty !== 1'b1) begin nerr++; $display("FAIL ovf_drained: got %b want 1", rd_empty); end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    send_word(1'b0, 32'h5555, 16, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_word(~i[0], {16'h0, vals[i]}, 16, i[0], 1'b0);
    end
    nvec++; if (rd_usedw !== 4'd8) begin nerr++; $display("FAIL fpp_full: got %0d want 8", rd_usedw); end
    send_word(1'b1, {16'h0, vals[8]}, 16, 1'b0, 1'b1);
    repeat (2) @(negedge pclk);
    nvec++; if ({overflow, rd_usedw} !== {1'b0, 4'd8}) begin nerr++; $display("FAIL fpp_usedw_ovf: got ovf=%b usedw=%0d want 0/8", overflow, rd_usedw); end
    for (int i = 1; i < 9; i++) begin
      nvec++;
      if ({chan, dataout} !== {~i[0], vals[i]}) begin
        nerr++; $display("FAIL fpp_order[%0d]: got %h want %h", i, {chan, dataout}, {~i[0], vals[i]});
      end
      pop_one();
    end
  endtask

  task automatic test_short_word();
    int f0;
    apply_reset();
    f0 = ferr_seen;
    send_word(1'b0, 32'h0000, 16, 1'b1, 1'b0);
    send_word(1'b1, 32'h0ABC, 12, 1'b0, 1'b0);
    repeat (2) @(negedge pclk);
    nvec++; if (ferr_seen - f0 !== 1) begin nerr++; $display("FAIL short_ferr: got %0d pulse cycles want 1", ferr_seen - f0); end
    nvec++; if (rd_usedw !== 4'd0) begin nerr++; $display("FAIL short_nopush: got %0d want 0", rd_usedw); end
    send_word(1'b0, 32'h1234, 16, 1'b1, 1'b0);
    nvec++; if ({rd_usedw, chan, dataout} !== {4'd1, 1'b0, 16'h1234}) begin nerr++; $display("FAIL short_next: got %h want 1_0_1234", {rd_usedw, chan, dataout}); end
    nvec++; if (ferr_seen - f0 !== 1) begin nerr++; $display("FAIL short_ferr_once: got %0d want 1", ferr_seen - f0); end
    pop_one();
  endtask

  task automatic test_long_word();
    int f0;
    apply_reset();
    f0 = ferr_seen;
    send_word(1'b0, 32'h0, 24, 1'b1, 1'b0);
    send_word(1'b1, 32'h7B3A49, 24, 1'b0, 1'b0);
    send_word(1'b0, 32'h7B3A49, 24, 1'b1, 1'b0);
    nvec++; if (rd_usedw !== 4'd2) begin nerr++; $display("FAIL long_usedw: got %0d want 2", rd_usedw); end
    nvec++; if ({chan, dataout} !== {1'b1, 16'h7B3A}) begin nerr++; $display("FAIL long_trunc_r: got %h want 17b3a", {chan, dataout}); end
    pop_one();
    nvec++; if ({chan, dataout} !== {1'b0, 16'h7B3A}) begin nerr++; $display("FAIL long_trunc_l: got %h want 07b3a", {chan, dataout}); end
    pop_one();
    nvec++; if (ferr_seen - f0 !== 0) begin nerr++; $display("FAIL long_no_ferr: got %0d want 0", ferr_seen - f0); end
  endtask

  task automatic test_reset_midword();
    int f0;
    apply_reset();
    send_word(1'b0, 32'h5555, 16, 1'b1, 1'b0);
    send_word(1'b1, 32'h1357, 16, 1'b0, 1'b0);
    send_word(1'b0, 32'h2468, 16, 1'b1, 1'b0);
    send_word(1'b1, 32'h369C, 16, 1'b0, 1'b0);
    nvec++; if (rd_usedw !== 4'd3) begin nerr++; $display("FAIL mid_queued: got %0d want 3", rd_usedw); end
    for (int k = 15; k >= 8; k--) send_bit(1'b0, k[0], 1'b0);
    bclk = 1'b0;
    #10;
    presetn = 1'b0;
    #1;
    nvec++; if ({rd_empty, rd_usedw, dataout} !== {1'b1, 4'd0, 16'h0}) begin nerr++; $display("FAIL mid_async_clear: got %h want 1_0_0000", {rd_empty, rd_usedw, dataout}); end
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);
    f0 = ferr_seen;
    send_word(1'b0, 32'h00A5, 8, 1'b1, 1'b0);
    repeat (2) @(negedge pclk);
    nvec++; if (rd_usedw !== 4'd0) begin nerr++; $display("FAIL mid_partial_drop: got %0d want 0", rd_usedw); end
    send_word(1'b1, 32'hC3C3, 16, 1'b0, 1'b0);
    send_word(1'b0, 32'h3C3C, 16, 1'b1, 1'b0);
    nvec++; if ({rd_usedw, chan, dataout} !== {4'd2, 1'b1, 16'hC3C3}) begin nerr++; $display("FAIL mid_after_r: got %h want 2_1_c3c3", {rd_usedw, chan, dataout}); end
    pop_one();
    nvec++; if ({chan, dataout} !== {1'b0, 16'h3C3C}) begin nerr++; $display("FAIL mid_after_l: got %h want 0_3c3c", {chan, dataout}); end
    nvec++; if (ferr_seen - f0 !== 0) begin nerr++; $display("FAIL mid_no_ferr: got %0d want 0", ferr_seen - f0); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_overflow();
    test_full_push_pop();
    test_short_word();
    test_long_word();
    test_reset_midword();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
